// File: rtl/pulse_stretch_pkg.sv
// rtl/pulse_stretch_pkg.sv - shared state encoding and default widths for the pulse stretcher
package pulse_stretch_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int PEND_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down counter holding the pending-strobe queue depth
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         nz_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign full_o = (cnt_q == '1);
  assign nz_o   = (cnt_q != '0);
  assign cnt_o  = cnt_q;

  // Simultaneous inc and dec cancel; an inc at full is simply lost.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      if (!full_o) cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (nz_o) cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches strobes into level windows with minimum gap and queued retriggers
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PEND_W = PEND_W_DEF,
  parameter bit RETRIG = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_pulse,
  input  logic [CNT_W-1:0]  i_width,
  input  logic [CNT_W-1:0]  i_gap,
  input  logic              i_clr_ovf,
  output logic              o_level,
  output logic              o_busy,
  output logic              o_done,
  output logic [PEND_W-1:0] o_pend_cnt,
  output logic              o_overflow
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             q_inc, q_dec;
  logic             q_full, q_nz;
  logic             drop;
  logic [CNT_W-1:0] w_m1;
  logic [CNT_W-1:0] g_m1;

  // A zero width still produces a one-cycle window.
  assign w_m1 = (i_width == '0) ? '0 : i_width - CNT_W'(1);
  assign g_m1 = i_gap - CNT_W'(1);

  sat_updown_cnt #(
    .W (PEND_W)
  ) u_pend (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (q_inc),
    .dec_i  (q_dec),
    .cnt_o  (o_pend_cnt),
    .full_o (q_full),
    .nz_o   (q_nz)
  );

  assign drop = q_inc && !q_dec && q_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    q_inc   = 1'b0;
    q_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_pulse) begin
          state_d = ST_HOLD;
          cnt_d   = w_m1;
        end
      end
      ST_HOLD: begin
        if (RETRIG && i_pulse) begin
          cnt_d = w_m1;
        end else if (cnt_q == '0) begin
          done_d = 1'b1;
          if (i_gap != '0) begin
            state_d = ST_GAP;
            cnt_d   = g_m1;
            q_inc   = i_pulse;
          end else if (q_nz) begin
            cnt_d = w_m1;
            q_dec = 1'b1;
            q_inc = i_pulse;
          end else if (i_pulse) begin
            cnt_d = w_m1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          q_inc = i_pulse;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (q_nz) begin
            state_d = ST_HOLD;
            cnt_d   = w_m1;
            q_dec   = 1'b1;
            q_inc   = i_pulse;
          end else if (i_pulse) begin
            state_d = ST_HOLD;
            cnt_d   = w_m1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          q_inc = i_pulse;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A fresh overflow beats a clear arriving in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_level    = (state_q == ST_HOLD);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Inverse companion of the level-to-pulse generator: converts single-cycle strobes into clean level windows of programmable width.
- Enforces a programmable minimum low gap between windows.
- Queues strobes that arrive while busy, so the level can drive slow-domain consumers such as handshake enables or LED/debug outputs.
- Sits between control FSMs and multi-cycle consumers in the same clock domain.

Parameters:
- CNT_W, 8: width of the width/gap counters and the i_width/i_gap inputs.
- PEND_W, 4: width of the pending-strobe counter; saturates at 2^PEND_W-1.
- RETRIG, 0: 0 = strobes during HOLD are queued; 1 = strobes during HOLD reload the width counter (extend the window).

Ports:
- CLK  input  1  block clock, all logic on rising edge.
- RST  input  1  synchronous active-high reset.
- i_pulse  input  1  strobe, sampled every cycle; each high cycle is one event.
- i_width  input  CNT_W  high-window length in cycles; 0 is treated as 1.
- i_gap  input  CNT_W  minimum low cycles after a window; 0 means no gap.
- i_clr_ovf  input  1  clears o_overflow.
- o_level  output  1  stretched level.
- o_busy  output  1  high whenever the state is not IDLE.
- o_done  output  1  one-cycle pulse after the last high cycle of each window.
- o_pend_cnt  output  PEND_W  number of queued strobes.
- o_overflow  output  1  sticky flag: a strobe was dropped because the queue was full.

Behaviour:
- Reset (RST=1 at an edge): state IDLE; counters 0; all outputs 0 from the following cycle. Reset mid-window aborts the window immediately and discards the queue and overflow flag.
- States: IDLE, HOLD, GAP.
- IDLE: i_pulse=1 -> HOLD at next edge. o_level is high from the next cycle (latency 1). W = max(i_width,1) is latched; the counter loads W-1.
- HOLD: o_level=1. Counter decrements each cycle. At counter==0 the window ends:
  - i_gap latched nonzero -> GAP with counter loaded i_gap-1.
  - i_gap zero and queue nonzero (or strobe in this cycle) -> HOLD again with a fresh W; the queue decrements.
  - Otherwise -> IDLE.
  - The gap value is latched at the end of HOLD.
- o_done is high in the cycle immediately following the final HOLD cycle of each window. This holds even when a back-to-back window keeps o_level high, giving a continuous 2W high level with one o_done per window.
- GAP: o_level=0. At counter==0: queue nonzero or strobe this cycle -> HOLD (consume one event); else -> IDLE.
- Queue rules:
  - A strobe in HOLD (RETRIG=0) or GAP increments o_pend_cnt.
  - A strobe at max count is dropped and sets o_overflow.
  - Consume and strobe in the same cycle -> count unchanged (net zero); no overflow.
  - A strobe in the cycle a window starts from the queue is queued.
  - A strobe in the exit cycle of HOLD/GAP with an empty queue starts the next window directly and is not counted.
- RETRIG=1: a strobe in HOLD reloads the counter with max(i_width,1)-1 using the current i_width; it is not queued and produces no extra o_done. Strobes in GAP queue as above.
- i_width/i_gap changes mid-window have no effect until the next latch point.
- o_overflow is cleared by i_clr_ovf. If i_clr_ovf and a new overflow occur in the same cycle, set wins.
- o_busy = (state != IDLE), registered together with the state.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, HOLD=2'b01, GAP=2'b10), plus CNT_W and PEND_W defaults.
- One natural sub-module: sat_updown_cnt (PEND_W wide, inc/dec inputs, saturation at max, full flag) for the pending queue.
- Width/gap down-counter and FSM stay in the top module.

Test Plan:
- Single strobe, i_width=4, i_gap=2, strobe at edge t0 -> o_level high t1..t4; o_done at t5; o_busy low from t7; o_pend_cnt stays 0.
- Three strobes on consecutive cycles t0..t2, i_width=3, i_gap=1, RETRIG=0 -> windows t1-t3, t5-t7, t9-t11; o_pend_cnt peaks at 2; three o_done pulses.
- i_gap=0, two strobes t0,t1, i_width=2 -> o_level high t1..t4 continuously; o_done at t3 and t5.
- RETRIG=1, i_width=4, strobes at t0 and t3 -> o_level high t1..t7; single o_done at t8; queue 0.
- PEND_W=2, i_width=10, five strobes during HOLD -> o_pend_cnt saturates at 3; o_overflow=1 and stays until i_clr_ovf pulse; exactly four windows total.
- RST asserted mid-HOLD with o_pend_cnt=2 -> next cycle o_level=0, o_busy=0, o_pend_cnt=0, o_overflow=0, no o_done; a strobe after reset starts a fresh window with latency 1.
